// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply scheduler and its MAC datapath.
package matmul_pkg;

  localparam int unsigned MAX_N  = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned ACC_W  = 19;
  localparam int unsigned RES_W  = 16;
  localparam int unsigned IDX_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/matmul_mac.sv
// Multiply-accumulate for one C element; output mapping selected by MATMUL_SAT_EN
// (defined: saturate to 16'hFFFF, undefined: truncate to the low 16 bits).
module matmul_mac #(
  parameter int unsigned DATA_W = matmul_pkg::DATA_W,
  parameter int unsigned ACC_W  = matmul_pkg::ACC_W,
  parameter int unsigned RES_W  = matmul_pkg::RES_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              first,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [RES_W-1:0]  res
);

  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    acc;

  assign prod = a * b;

  // The first product of an element overwrites the accumulator, so no clear cycle is needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= first ? ACC_W'(prod) : acc + ACC_W'(prod);
    end
  end

`ifdef MATMUL_SAT_EN
  localparam logic [ACC_W-1:0] RES_MAX = ACC_W'({RES_W{1'b1}});
  assign res = (acc > RES_MAX) ? '1 : RES_W'(acc);
`else
  assign res = RES_W'(acc);
`endif

endmodule

// File: rtl/matmul_scheduler.sv
// Sequences C = A*B over externally loaded buffers: address generation, MAC control,
// result writes. Optional saturation of res_data via MATMUL_SAT_EN (see matmul_mac).
module matmul_scheduler
  import matmul_pkg::*;
#(
  parameter int unsigned MAX_N  = matmul_pkg::MAX_N,
  parameter int unsigned DATA_W = matmul_pkg::DATA_W,
  parameter int unsigned ADDR_W = matmul_pkg::ADDR_W,
  parameter int unsigned ACC_W  = matmul_pkg::ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IDX_W-1:0]  matrix_size,
  output logic              busy,
  output logic              done,
  output logic              size_err,
  output logic              a_rd_en,
  output logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              b_rd_en,
  output logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              res_we,
  output logic [ADDR_W-1:0] res_addr,
  output logic [RES_W-1:0]  res_data
);

  localparam logic [IDX_W-1:0] N_MAX = IDX_W'(MAX_N);

  state_t            state;
  logic [IDX_W-1:0]  n;
  logic [IDX_W-1:0]  i;
  logic [IDX_W-1:0]  j;
  logic [IDX_W-1:0]  k;
  logic [ADDR_W-1:0] a_row;
  logic              mac_vld;
  logic              mac_first;
  logic              last_i;
  logic              last_j;
  logic              last_k;
  logic [ADDR_W-1:0] n_step;
  logic [ADDR_W-1:0] j_ext;

  assign last_i = (i == n - 1'b1);
  assign last_j = (j == n - 1'b1);
  assign last_k = (k == n - 1'b1);
  assign n_step = ADDR_W'(n);
  assign j_ext  = ADDR_W'(j);
  assign busy   = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      n         <= '0;
      i         <= '0;
      j         <= '0;
      k         <= '0;
      a_row     <= '0;
      a_addr    <= '0;
      b_addr    <= '0;
      res_addr  <= '0;
      a_rd_en   <= 1'b0;
      b_rd_en   <= 1'b0;
      res_we    <= 1'b0;
      done      <= 1'b0;
      size_err  <= 1'b0;
      mac_vld   <= 1'b0;
      mac_first <= 1'b0;
    end else begin
      // Read data returns one cycle after issue, so the MAC controls trail the strobes by one.
      mac_vld   <= (state == ST_ISSUE);
      mac_first <= (state == ST_ISSUE) && (k == '0);
      size_err  <= 1'b0;
      done      <= 1'b0;
      res_we    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (matrix_size != '0 && matrix_size <= N_MAX) begin
              n        <= matrix_size;
              i        <= '0;
              j        <= '0;
              k        <= '0;
              a_row    <= '0;
              a_addr   <= '0;
              b_addr   <= '0;
              res_addr <= '0;
              a_rd_en  <= 1'b1;
              b_rd_en  <= 1'b1;
              state    <= ST_ISSUE;
            end else begin
              size_err <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (last_k) begin
            a_rd_en <= 1'b0;
            b_rd_en <= 1'b0;
            state   <= ST_DRAIN;
          end else begin
            k      <= k + 1'b1;
            a_addr <= a_addr + 1'b1;
            b_addr <= b_addr + n_step;
          end
        end
        ST_DRAIN: begin
          res_we <= 1'b1;
          state  <= ST_WRITE;
        end
        ST_WRITE: begin
          res_addr <= res_addr + 1'b1;
          k        <= '0;
          if (last_i && last_j) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            a_rd_en <= 1'b1;
            b_rd_en <= 1'b1;
            state   <= ST_ISSUE;
            // a_row tracks i*N; the next element's k=0 addresses are seeded from it and from j.
            if (last_j) begin
              j      <= '0;
              i      <= i + 1'b1;
              a_row  <= a_row + n_step;
              a_addr <= a_row + n_step;
              b_addr <= '0;
            end else begin
              j      <= j + 1'b1;
              a_addr <= a_row;
              b_addr <= j_ext + 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  matmul_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .RES_W  (RES_W)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .en    (mac_vld),
    .first (mac_first),
    .a     (a_data),
    .b     (b_data),
    .res   (res_data)
  );

endmodule

// File: doc/matmul_scheduler.md
Name: matmul_scheduler

Overview:
- Sequences one N×N matrix multiply, C = A·B, after the host-side control FSM has loaded matrices A and B into buffers.
- Generates read addresses for the A and B buffers and accumulates products internally.
- Writes each C element to the result buffer.
- Sits between the control FSM (start/done handshake) and the three matrix buffers. Replaces the FSM's direct read-enable strobing.

Parameters:
- MAX_N, 8: largest supported matrix dimension.
- DATA_W, 8: width of A/B elements, unsigned.
- ADDR_W, 6: buffer address width; must be ≥ clog2(MAX_N*MAX_N).
- ACC_W, 19: accumulator width, equal to 2*DATA_W + clog2(MAX_N).

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous reset, active-high.
- start, in, 1: request to begin; sampled only in IDLE.
- matrix_size, in, 4: N; latched when start is accepted.
- busy, out, 1: high whenever state ≠ IDLE.
- done, out, 1: one-cycle pulse when all of C is written.
- size_err, out, 1: one-cycle pulse when start arrives with an invalid N.
- a_rd_en, out, 1: read strobe for the A buffer.
- a_addr, out, ADDR_W: A address, row-major, i*N+k.
- a_data, in, DATA_W: A read data, valid 1 cycle after a_rd_en.
- b_rd_en, out, 1: read strobe for the B buffer.
- b_addr, out, ADDR_W: B address, row-major, k*N+j.
- b_data, in, DATA_W: B read data, valid 1 cycle after b_rd_en.
- res_we, out, 1: result write strobe.
- res_addr, out, ADDR_W: C address, i*N+j.
- res_data, out, 16: C element value.

Behaviour:
- Reset: all outputs 0, state IDLE, accumulator and indices i/j/k cleared. Applies mid-operation too: no further res_we, and no done pulse.
- States: IDLE, ISSUE, DRAIN, WRITE, DONE.
- IDLE:
  - If start=1 and 1 ≤ matrix_size ≤ MAX_N: latch N, set i=j=k=0, go to ISSUE.
  - If start=1 and matrix_size is 0 or > MAX_N: pulse size_err next cycle and stay in IDLE.
- ISSUE (N cycles):
  - a_rd_en=b_rd_en=1 with a_addr=i*N+k and b_addr=k*N+j.
  - k increments each cycle. After k=N-1 is issued, go to DRAIN.
- Accumulation: on each cycle after a read issue, the product a_data*b_data is loaded into the accumulator if it belongs to k=0, otherwise added. No separate clear cycle.
- DRAIN (1 cycle): absorbs the last product. No read strobes.
- WRITE (1 cycle):
  - res_we=1, res_addr=i*N+j, res_data=accumulator mapped to 16 bits (see Optional Feature).
  - Advance j. On wrap, j=0 and i increments.
  - If i=N-1 and j=N-1 were just written, go to DONE; otherwise go to ISSUE with k=0.
- DONE (1 cycle): done=1, then return to IDLE.
- Timing: each element takes N+2 cycles. With start accepted at edge 0:
  - last res_we occurs at cycle N*N*(N+2);
  - done occurs at cycle N*N*(N+2)+1.
- start while busy is ignored. matrix_size changes while busy are ignored.
- Addressing: computed with incremental pointers, not multipliers. Pointers add 1 for a_addr/res_addr and add N for b_addr.
- Arithmetic: unsigned. The accumulator cannot overflow for N ≤ MAX_N.
- Strobes (res_we, a_rd_en, b_rd_en) are registered outputs.

Optional Feature:
- Macro: MATMUL_SAT_EN.
- Defined: res_data = 16'hFFFF if accumulator > 16'hFFFF, otherwise accumulator[15:0].
- Undefined: res_data = accumulator[15:0] (plain truncation).

Decomposition:
- Shared package matmul_pkg holds:
  - state encoding localparams (IDLE/ISSUE/DRAIN/WRITE/DONE);
  - MAX_N, DATA_W, ADDR_W, ACC_W defaults;
  - RES_W=16.
- One natural sub-module, matmul_mac: DATA_W×DATA_W multiply with load/accumulate control and the saturate/truncate output mapping.
- The FSM, index counters and address pointers stay in matmul_scheduler.

Test Plan:
- N=2, A=[1 2;3 4], B=[5 6;7 8] -> res_we writes 19, 22, 43, 50 at res_addr 0, 1, 2, 3; last write at cycle 16, done at cycle 17.
- N=1, A=3, B=9 -> single write 27 at res_addr 0 on cycle 3; done at cycle 4; busy high for cycles 1–4.
- start with matrix_size=0, then with 9 (MAX_N=8) -> size_err pulses once each; busy, res_we and a_rd_en stay 0.
- N=8, all elements 255 -> every C element is 520200. With MATMUL_SAT_EN: res_data=0xFFFF. Without it: res_data=0xF008. 64 writes, done at cycle 641.
- N=3 run with start re-pulsed and matrix_size changed mid-run -> results and timing identical to an undisturbed N=3 run.
- N=3, rst asserted during 2nd element's ISSUE -> next cycle all outputs 0 and state IDLE, no done pulse. A following start with N=2 runs correctly from scratch.
